// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES S-box / P-permutation stage:
//   - DES_HALF_W / DES_EXP_W : 32-bit half-block and 48-bit expanded widths
//   - des_state_e            : control states of the iterative substitution
//   - SBOX                   : eight S-box tables, 64 entries each, indexed {row,col}
//   - P_TABLE                : DES P permutation, out[i] = s[P_TABLE[i]]
//   - des_perm()             : applies P to a 32-bit word numbered [1:32]
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int unsigned DES_HALF_W = 32;
    localparam int unsigned DES_EXP_W  = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUBST,
        ST_DONE
    } des_state_e;

    // Each table is laid out row-major: entry index = row*16 + col.
    localparam logic [3:0] SBOX [0:7][0:63] = '{
        '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
          4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
          4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
          4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13},
        '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
          4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
          4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
          4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9},
        '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
          4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
          4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
          4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12},
        '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
          4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
          4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
          4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14},
        '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
          4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
          4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
          4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3},
        '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
          4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
          4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
          4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13},
        '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
          4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
          4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
          4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12},
        '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
          4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
          4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
          4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
    };

    localparam logic [5:0] P_TABLE [1:32] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    function automatic logic [1:DES_HALF_W] des_perm(input logic [1:DES_HALF_W] s);
        logic [1:DES_HALF_W] r;
        r = '0;
        for (int unsigned i = 1; i <= DES_HALF_W; i++) begin
            r[i] = s[P_TABLE[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/des_sbox_perm_if.sv
// -----------------------------------------------------------------------------
// des_sbox_perm_if
// Handshake bundle for the S-box / P stage.
//   in_valid/in_ready/in_data    : 48-bit word, bit 0 = DES bit 1 (leftmost)
//   out_valid/out_ready/out_data : 32-bit f(R,K), bit 1 = DES bit 1 (leftmost)
// master = upstream/downstream environment, slave = des_sbox_perm.
// -----------------------------------------------------------------------------
interface des_sbox_perm_if;
    import des_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [0:DES_EXP_W-1]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:DES_HALF_W]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/des_sbox_lookup.sv
// -----------------------------------------------------------------------------
// des_sbox_lookup
// Combinational single S-box evaluation.
//   box_i   : S-box index 0..7 (0 selects S1)
//   group_i : 6-bit group, group_i[5] = leftmost DES bit of the group
//   value_o : 4-bit S-box output, value_o[3] = leftmost
// -----------------------------------------------------------------------------
module des_sbox_lookup
    import des_pkg::*;
(
    input  logic [2:0] box_i,
    input  logic [5:0] group_i,
    output logic [3:0] value_o
);
    // Row is the outer bit pair, column the inner four bits.
    logic [5:0] idx;

    assign idx     = {group_i[5], group_i[0], group_i[4:1]};
    assign value_o = SBOX[box_i][idx];
endmodule

// File: rtl/des_sbox_perm.sv
// -----------------------------------------------------------------------------
// des_sbox_perm
// Iterative DES S-box substitution followed by the P permutation, producing
// f(R,K) from the 48-bit key-mixed word. SBOX_PER_CYCLE boxes are evaluated
// per clock; the result is held on the output until accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : des_sbox_perm_if.slave (in_* accept side, out_* result side)
// -----------------------------------------------------------------------------
module des_sbox_perm
    import des_pkg::*;
#(
    parameter int unsigned SBOX_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    des_sbox_perm_if.slave    bus
);
    localparam int unsigned NUM_STEPS = 8 / SBOX_PER_CYCLE;
    localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

    if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 &&
        SBOX_PER_CYCLE != 4 && SBOX_PER_CYCLE != 8) begin : g_bad_param
        $error("des_sbox_perm: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
    end

    des_state_e           state_q;
    logic [2:0]           cnt_q;
    logic [0:DES_EXP_W-1] in_q;
    logic [1:DES_HALF_W]  subst_q;
    logic [1:DES_HALF_W]  subst_d;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [1:DES_HALF_W]  out_data_q;

    logic [2:0] lane_box [SBOX_PER_CYCLE];
    logic [3:0] lane_val [SBOX_PER_CYCLE];

    for (genvar j = 0; j < SBOX_PER_CYCLE; j++) begin : g_lane
        logic [5:0] grp;

        assign lane_box[j] = 3'(cnt_q * SBOX_PER_CYCLE + j);
        assign grp         = in_q[6*lane_box[j] +: 6];

        des_sbox_lookup u_lookup (
            .box_i   (lane_box[j]),
            .group_i (grp),
            .value_o (lane_val[j])
        );
    end

    always_comb begin
        subst_d = subst_q;
        for (int unsigned j = 0; j < SBOX_PER_CYCLE; j++) begin
            subst_d[4*lane_box[j]+1 +: 4] = lane_val[j];
        end
    end

    // P is taken from subst_d so the final step's nibbles are included in
    // the registered output on the same edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_q        <= '0;
            subst_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_q       <= bus.in_data;
                        cnt_q      <= '0;
                        subst_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SUBST;
                    end
                end
                ST_SUBST: begin
                    subst_q <= subst_d;
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == LAST_STEP) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= des_perm(subst_d);
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: doc/des_sbox_perm.md
Name: des_sbox_perm

Overview:
- Reverse direction of the DES E-expansion: compresses the 48-bit post-key-mix word (E(R) xor Kn) back to 32 bits.
- Applies the eight DES S-boxes, then the P permutation, to produce the round-function output f(R,K).
- Iterative: evaluates SBOX_PER_CYCLE S-boxes per clock, with valid/ready handshakes on input and output.
- Sits between the key-mix xor and the L/R swap in the round datapath.

Parameters:
SBOX_PER_CYCLE, 1, S-boxes evaluated per clock; legal values 1, 2, 4, 8; any other value is a compile-time error.
NUM_STEPS, 8/SBOX_PER_CYCLE, derived localparam, not overridable.

Ports:
clk      input   1   clock, rising edge
rst_n    input   1   asynchronous active-low reset
in_valid input   1   in_data valid
in_ready output  1   block can accept in_data
in_data  input   48  bits [0:47]; bit 0 = DES bit 1 (leftmost); 6-bit group g = bits [6g:6g+5], g=0 feeds S1
out_valid output 1   out_data valid
out_ready input  1   downstream accepts out_data
out_data output  32  bits [1:32]; bit 1 = DES bit 1 (leftmost); f = P(S1..S8)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, step counter=0, 48-bit input register=0, 32-bit substitution register=0.
  - in_ready=1, out_valid=0, out_data=0.
- States: IDLE, SUBST, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data, clear counter and substitution register, go to SUBST.
- SUBST:
  - in_ready=0.
  - Each clock, for lanes j=0..SBOX_PER_CYCLE-1, g = counter*SBOX_PER_CYCLE + j.
  - row = {b[6g], b[6g+5]}; col = b[6g+1:6g+4]; the 4-bit S_{g+1}(row,col) is written to substitution bits [4g+1:4g+4].
  - Counter increments. When counter == NUM_STEPS-1, go to DONE on the same edge.
  - in_valid is ignored.
- DONE:
  - out_valid=1; out_data = P(substitution register), registered and stable while out_valid=1.
  - P uses the standard DES table: out[i] = s[P[i]], P = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
  - On out_ready=1: go to IDLE, out_valid falls on the next edge.
  - in_ready=0 throughout DONE, so no simultaneous accept and emit.
- Latency:
  - Accept at edge k; out_valid=1 after edge k+NUM_STEPS (8 for default, 1 for SBOX_PER_CYCLE=8).
  - Minimum initiation interval NUM_STEPS+2 clocks with out_ready held high.
- Backpressure: out_ready=0 holds DONE indefinitely; out_data must not change.
- in_data changing after the accept edge has no effect.
- Reset mid-operation (SUBST or DONE): immediate return to reset values; the partial result is discarded, never emitted.
- out_valid is never asserted without a completed 8-box substitution.

Decomposition:
- Package des_pkg:
  - SBOX[0:7][0:63] 4-bit tables, indexed {row,col}.
  - P_TABLE[1:32].
  - Widths: DES_HALF_W=32, DES_EXP_W=48.
  - State enum type.
- Sub-module des_sbox_lookup: combinational; inputs 3-bit box index and 6-bit group; output 4-bit value. Instantiated SBOX_PER_CYCLE times.
- P permutation is a function in des_pkg.

Test Plan:
- Textbook round-1 vector: in_data=0x6117BA866527 -> substitution register 0x5C82B597, out_data=0x234AA9BB, out_valid 8 clocks after accept (SBOX_PER_CYCLE=1).
- Same vector with SBOX_PER_CYCLE=2/4/8 -> same out_data; latency 4/2/1 clocks.
- in_data=0 -> substitution register 0xEFA72C4D (row 0, col 0 of S1..S8); out_data must match P(0xEFA72C4D) from the reference model.
- out_ready=0 for 20 clocks in DONE -> out_valid stays 1, out_data constant, in_ready=0. Then out_ready=1 -> IDLE next clock, in_ready=1.
- Assert rst_n=0 at step 4 of SUBST, release, send 0x6117BA866527 -> no spurious out_valid; single correct result 0x234AA9BB.
- Back-to-back: in_valid held high with two vectors, out_ready=1 -> both results in order, second accept exactly one clock after the first out handshake.
